// File: rtl/dr_scanreg_4ph.sv
// dr_scanreg_4ph: registers one of NUM_IN dual-rail operands (picked by a dual-rail select) under a 4-phase req/ack handshake, with illegal-codeword detection, sticky err and a wrapping transfer count
module dr_scanreg_4ph #(
  parameter int WIDTH = 4,
  parameter int NUM_IN = 2,
  parameter int RTZ_OUT = 1,
  parameter int CNT_W = 8,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_t,
  input  logic [NUM_IN*WIDTH-1:0] in_f,
  input  logic [SEL_W-1:0]        sel_t,
  input  logic [SEL_W-1:0]        sel_f,
  input  logic                    req,
  output logic                    ack,
  output logic [WIDTH-1:0]        q_t,
  output logic [WIDTH-1:0]        q_f,
  output logic                    err,
  output logic [CNT_W-1:0]        xfer_cnt
);
  typedef enum logic [1:0] {IDLE, ACKH, ERR} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] q_t_n, q_f_n, mux_t, mux_f;
  logic [CNT_W-1:0] cnt_n;
  logic err_n, complete, spacer_all, illegal;
  assign complete = &(in_t ^ in_f) & &(sel_t ^ sel_f);
  assign spacer_all = ~|{in_t, in_f, sel_t, sel_f};
  assign illegal = |(in_t & in_f) | |(sel_t & sel_f) |
                   (complete & ({1'b0, sel_t} >= (SEL_W+1)'(NUM_IN)));
  assign ack = state == ACKH;
  always_comb begin
    mux_t = '0;
    mux_f = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      mux_t = sel_t == SEL_W'(k) ? in_t[k*WIDTH +: WIDTH] : mux_t;
      mux_f = sel_t == SEL_W'(k) ? in_f[k*WIDTH +: WIDTH] : mux_f;
    end
  end
  always_comb begin
    state_n = state;
    q_t_n = q_t;
    q_f_n = q_f;
    cnt_n = xfer_cnt;
    err_n = err;
    case (state)
      IDLE: begin
        if (illegal) state_n = ERR;
        else if (req && complete) begin
          state_n = ACKH;
          q_t_n = mux_t;
          q_f_n = mux_f;
          cnt_n = xfer_cnt + CNT_W'(1);
        end
      end
      ACKH: begin
        if (illegal) state_n = ERR;
        else if (!req && spacer_all) begin
          state_n = IDLE;
          q_t_n = RTZ_OUT != 0 ? '0 : q_t;
          q_f_n = RTZ_OUT != 0 ? '0 : q_f;
        end
      end
      default: state_n = (!req && spacer_all) ? IDLE : ERR;
    endcase
    if (state_n == ERR) begin
      err_n = 1'b1;
      q_t_n = '0;
      q_f_n = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      q_t <= '0;
      q_f <= '0;
      xfer_cnt <= '0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      q_t <= q_t_n;
      q_f <= q_f_n;
      xfer_cnt <= cnt_n;
      err <= err_n;
    end
  end
endmodule
